// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MIPS core data port (master) and its memory responder (slave).
interface dmem_responder_if;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [1:0]  memwrite;
    logic        memread;
    logic [1:0]  loadsize;
    logic        loadunsigned;
    logic [31:0] readdata;
    logic        stall;
    logic        done;
    logic        misalign;

    modport master (
        output dataadr, writedata, memwrite, memread, loadsize, loadunsigned,
        input  readdata, stall, done, misalign
    );

    modport slave (
        input  dataadr, writedata, memwrite, memread, loadsize, loadunsigned,
        output readdata, stall, done, misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store, stalls the core for LATENCY
// cycles, then performs the access and pulses done (with misalign on bad alignment).
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    typedef struct packed {
        logic [AW+1:0] addr;
        logic [31:0]   wdata;
        logic [1:0]    size;
        logic          is_write;
        logic          uns;
        logic          illegal;
    } req_t;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [31:0] readdata_q, readdata_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;

    logic [31:0] mem [DEPTH];

    req_t        in_req, cur;
    logic        request, enter_resp, misaligned, mem_we;
    logic [AW-1:0] idx;
    logic [31:0] mem_word, lane_word, load_data, wr_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.dataadr[31:AW+2];
    assign request = (bus.memwrite != 2'b00) || bus.memread;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_req          = '0;
        in_req.addr     = bus.dataadr[AW+1:0];
        in_req.wdata    = bus.writedata;
        in_req.is_write = (bus.memwrite != 2'b00);
        in_req.size     = in_req.is_write ? bus.memwrite
                        : (bus.loadsize == 2'b00 ? SZ_WORD : bus.loadsize);
        in_req.uns      = bus.loadunsigned;
        in_req.illegal  = in_req.is_write && bus.memread;
    end

    // With LATENCY==1 the access happens straight out of IDLE, before the request is latched.
    assign cur        = (state_q == IDLE) ? in_req : req_q;
    assign enter_resp = (state_q == IDLE && request && LATENCY == 1)
                     || (state_q == BUSY && cnt_q == 4'd1);
    assign misaligned = (cur.size == SZ_WORD && cur.addr[1:0] != 2'b00)
                     || (cur.size == SZ_HALF && cur.addr[0]);
    assign idx        = cur.addr[AW+1:2];
    assign mem_word   = mem[idx];
    assign mem_we     = reset && enter_resp && cur.is_write && !misaligned;

    always_comb begin
        lane_word = mem_word >> {cur.addr[1:0], 3'b000};
        case (cur.size)
            SZ_HALF: load_data = {{16{~cur.uns & lane_word[15]}}, lane_word[15:0]};
            SZ_BYTE: load_data = {{24{~cur.uns & lane_word[7]}}, lane_word[7:0]};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        wr_word = mem_word;
        case (cur.size)
            SZ_HALF: wr_word[{cur.addr[1], 4'b0000} +: 16] = cur.wdata[15:0];
            SZ_BYTE: wr_word[{cur.addr[1:0], 3'b000} +: 8] = cur.wdata[7:0];
            default: wr_word = cur.wdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        readdata_d = readdata_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: if (request) begin
                req_d   = in_req;
                cnt_d   = 4'(LATENCY - 1);
                state_d = (LATENCY == 1) ? RESP : BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            done_d     = 1'b1;
            misalign_d = misaligned || cur.illegal;
            if (!cur.is_write && !misaligned) readdata_d = load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            readdata_q <= '0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            readdata_q <= readdata_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
        end
    end

    // NOTE: the storage array has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wr_word;
    end

    assign bus.readdata = readdata_q;
    assign bus.done     = done_q;
    assign bus.misalign = misalign_q;
    assign bus.stall    = reset && ((state_q == IDLE && request) || state_q == BUSY);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder: three instances (LATENCY 2, 1, 15)
// compared against a word-array memory model computed from the byte-lane rules.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int NU    = 3;
    localparam int LAT [NU] = '{2, 1, 15};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] adr [NU];
    logic [31:0] wd  [NU];
    logic [1:0]  mw  [NU];
    logic [1:0]  ls  [NU];
    logic        mr  [NU];
    logic        lu  [NU];
    logic [31:0] rdw [NU];
    logic        stw [NU];
    logic        dnw [NU];
    logic        msw [NU];

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.dataadr = adr[0]; assign bus0.writedata = wd[0]; assign bus0.memwrite = mw[0];
    assign bus0.memread = mr[0];  assign bus0.loadsize = ls[0];  assign bus0.loadunsigned = lu[0];
    assign rdw[0] = bus0.readdata; assign stw[0] = bus0.stall; assign dnw[0] = bus0.done; assign msw[0] = bus0.misalign;
    assign bus1.dataadr = adr[1]; assign bus1.writedata = wd[1]; assign bus1.memwrite = mw[1];
    assign bus1.memread = mr[1];  assign bus1.loadsize = ls[1];  assign bus1.loadunsigned = lu[1];
    assign rdw[1] = bus1.readdata; assign stw[1] = bus1.stall; assign dnw[1] = bus1.done; assign msw[1] = bus1.misalign;
    assign bus2.dataadr = adr[2]; assign bus2.writedata = wd[2]; assign bus2.memwrite = mw[2];
    assign bus2.memread = mr[2];  assign bus2.loadsize = ls[2];  assign bus2.loadunsigned = lu[2];
    assign rdw[2] = bus2.readdata; assign stw[2] = bus2.stall; assign dnw[2] = bus2.done; assign msw[2] = bus2.misalign;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2))  dut0 (.clk(clk), .reset(rst), .bus(bus0));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1))  dut1 (.clk(clk), .reset(rst), .bus(bus1));
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut2 (.clk(clk), .reset(rst), .bus(bus2));

    logic [31:0] mdl    [NU][DEPTH];
    logic [31:0] mdl_rd [NU];
    int          done_cyc [NU];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // One complete request on unit u; the caller is at a falling edge with the unit idle.
    task automatic xact(input int u, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] mw_i, input logic rd_i, input logic [1:0] ls_i,
                        input logic us_i, input string tag);
        int idx, sz, nb, lane, nst;
        logic is_wr, mis, exp_mis, got;
        logic [31:0] w, v;
        is_wr   = (mw_i != 2'b00);
        sz      = is_wr ? int'(mw_i) : (ls_i == 2'b00 ? 1 : int'(ls_i));
        mis     = (sz == 1 && a[1:0] != 2'b00) || (sz == 2 && a[0]);
        exp_mis = mis || (is_wr && rd_i);
        idx     = int'((a / 32'd4) % 32'(DEPTH));
        if (!mis && is_wr) begin
            nb = (sz == 1) ? 4 : (sz == 2) ? 2 : 1;
            for (int k = 0; k < nb; k++) begin
                lane = int'(a[1:0]) + k;
                mdl[u][idx][8*lane +: 8] = d[8*k +: 8];
            end
        end
        if (!mis && !is_wr) begin
            w = mdl[u][idx] >> (8 * int'(a[1:0]));
            case (sz)
                1:       v = w;
                2:       v = us_i ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
                default: v = us_i ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            endcase
            mdl_rd[u] = v;
        end

        adr[u] = a; wd[u] = d; mw[u] = mw_i; mr[u] = rd_i; ls[u] = ls_i; lu[u] = us_i;
        #1;
        nst = 0;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (dnw[u]) begin
                got = 1'b1;
                break;
            end
            if (stw[u]) nst++;
            @(negedge clk);
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s u%0d done_timeout: no done within 40 cycles, required one", tag, u);
        end else begin
            done_cyc[u] = cyc;
            n_checks++;
            if (nst != LAT[u]) begin
                n_fail++;
                $display("FAIL %s u%0d stall_cycles: got %0d required %0d", tag, u, nst, LAT[u]);
            end
            n_checks++;
            if (stw[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s u%0d stall_in_resp: got %b required 0", tag, u, stw[u]);
            end
            n_checks++;
            if (msw[u] !== exp_mis) begin
                n_fail++;
                $display("FAIL %s u%0d misalign: got %b required %b", tag, u, msw[u], exp_mis);
            end
            n_checks++;
            if (rdw[u] !== mdl_rd[u]) begin
                n_fail++;
                $display("FAIL %s u%0d readdata: got %h required %h", tag, u, rdw[u], mdl_rd[u]);
            end
        end
        mw[u] = 2'b00;
        mr[u] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dnw[u] !== 1'b0 || msw[u] !== 1'b0 || stw[u] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s u%0d after_resp: done=%b misalign=%b stall=%b required 0 0 0",
                     tag, u, dnw[u], msw[u], stw[u]);
        end
        n_checks++;
        if (rdw[u] !== mdl_rd[u]) begin
            n_fail++;
            $display("FAIL %s u%0d readdata_hold: got %h required %h", tag, u, rdw[u], mdl_rd[u]);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < NU; u++) begin
            adr[u] = '0; wd[u] = '0; mw[u] = 2'b00; mr[u] = 1'b0; ls[u] = 2'b00; lu[u] = 1'b0;
            mdl_rd[u] = '0;
        end
        rst = 1'b0;
        #12;
        for (int u = 0; u < NU; u++) begin
            n_checks++;
            if (rdw[u] !== 32'h0 || dnw[u] !== 1'b0 || msw[u] !== 1'b0 || stw[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset u%0d: readdata=%h done=%b misalign=%b stall=%b required 0",
                         u, rdw[u], dnw[u], msw[u], stw[u]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        xact(0, 32'h84, 32'hFFFF7F02, 2'b01, 1'b0, 2'b00, 1'b0, "word_store");
        xact(0, 32'h84, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0, "word_load");
        n_checks++;
        if (rdw[0] !== 32'hFFFF7F02) begin
            n_fail++;
            $display("FAIL word_value: got %h required FFFF7F02", rdw[0]);
        end
    endtask

    task automatic test_subword();
        xact(0, 32'h80, 32'h00000000, 2'b01, 1'b0, 2'b00, 1'b0, "sub_clear");
        xact(0, 32'h81, 32'h000000AB, 2'b11, 1'b0, 2'b00, 1'b0, "sub_byte");
        xact(0, 32'h82, 32'h00001234, 2'b10, 1'b0, 2'b00, 1'b0, "sub_half");
        xact(0, 32'h80, 32'h0, 2'b00, 1'b1, 2'b01, 1'b0, "sub_load");
        n_checks++;
        if (rdw[0] !== 32'h1234AB00) begin
            n_fail++;
            $display("FAIL subword_value: got %h required 1234AB00", rdw[0]);
        end
    endtask

    task automatic test_extend();
        logic [31:0] exp_v [3] = '{32'hFFFFFFAB, 32'h000000AB, 32'h00001234};
        logic [31:0] a_v   [3] = '{32'h81, 32'h81, 32'h82};
        logic [1:0]  s_v   [3] = '{2'b11, 2'b11, 2'b10};
        logic        u_v   [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            xact(0, a_v[i], 32'h0, 2'b00, 1'b1, s_v[i], u_v[i], "extend");
            n_checks++;
            if (rdw[0] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL extend_%0d: got %h required %h", i, rdw[0], exp_v[i]);
            end
        end
    endtask

    task automatic test_misalign();
        xact(0, 32'h86, 32'h11223344, 2'b01, 1'b0, 2'b00, 1'b0, "mis_store");
        xact(0, 32'h84, 32'h0, 2'b00, 1'b1, 2'b01, 1'b0, "mis_check");
        n_checks++;
        if (rdw[0] !== 32'hFFFF7F02) begin
            n_fail++;
            $display("FAIL misalign_nowrite: got %h required FFFF7F02", rdw[0]);
        end
        xact(0, 32'h83, 32'h0, 2'b00, 1'b1, 2'b10, 1'b0, "mis_load");
        n_checks++;
        if (rdw[0] !== 32'hFFFF7F02) begin
            n_fail++;
            $display("FAIL misalign_hold: got %h required FFFF7F02", rdw[0]);
        end
        xact(0, 32'h10, 32'h55, 2'b01, 1'b1, 2'b00, 1'b0, "illegal");
    endtask

    task automatic test_latency();
        for (int u = 1; u < NU; u++) begin
            xact(u, 32'h88, 32'hCAFE0000 + 32'(u), 2'b01, 1'b0, 2'b00, 1'b0, "lat_store");
            xact(u, 32'h88, 32'h0, 2'b00, 1'b1, 2'b00, 1'b0, "lat_load");
            n_checks++;
            if (rdw[u] !== 32'hCAFE0000 + 32'(u)) begin
                n_fail++;
                $display("FAIL lat_value u%0d: got %h required %h", u, rdw[u], 32'hCAFE0000 + 32'(u));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first;
        for (int u = 0; u < 2; u++) begin
            xact(u, 32'h90, 32'hA5A5A5A5, 2'b01, 1'b0, 2'b00, 1'b0, "b2b_a");
            first = done_cyc[u];
            xact(u, 32'h94, 32'h5A5A5A5A, 2'b01, 1'b0, 2'b00, 1'b0, "b2b_b");
            n_checks++;
            if (done_cyc[u] - first != LAT[u] + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing u%0d: got %0d required %0d", u, done_cyc[u] - first, LAT[u] + 1);
            end
        end
    endtask

    task automatic test_abort();
        logic seen_done;
        adr[0] = 32'h84; wd[0] = 32'hDEADBEEF; mw[0] = 2'b01; mr[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stw[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_stall: got %b required 1", stw[0]);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (stw[0] !== 1'b0 || dnw[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: stall=%b done=%b required 0 0", stw[0], dnw[0]);
        end
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen_done |= dnw[0];
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: got %b required 0", seen_done);
        end
        mw[0] = 2'b00;
        for (int u = 0; u < NU; u++) mdl_rd[u] = '0;
        rst = 1'b1;
        @(negedge clk);
        xact(0, 32'h84, 32'h0, 2'b00, 1'b1, 2'b01, 1'b0, "abort_load");
    endtask

    task automatic test_wrap();
        xact(0, 32'h84 + 32'(4 * DEPTH), 32'h0BADF00D, 2'b01, 1'b0, 2'b00, 1'b0, "wrap_store");
        xact(0, 32'h84, 32'h0, 2'b00, 1'b1, 2'b01, 1'b0, "wrap_load");
        n_checks++;
        if (rdw[0] !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL wrap_value: got %h required 0BADF00D", rdw[0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < 8; i++)
                xact(u, 32'h40 + 32'(4 * i), $urandom, 2'b01, 1'b0, 2'b00, 1'b0, "rnd_init");
            for (int i = 0; i < 25; i++) begin
                a  = 32'h40 + 32'($urandom_range(0, 31));
                sz = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1)
                    xact(u, a, $urandom, (sz == 2'b00) ? 2'b11 : sz, 1'b0, 2'b00, 1'b0, "rnd_store");
                else
                    xact(u, a, $urandom, 2'b00, 1'b1, sz, 1'($urandom_range(0, 1)), "rnd_load");
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_extend();
        test_misalign();
        test_latency();
        test_back_to_back();
        test_abort();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end
endmodule
